// File: rtl/axi_wr_pkg.sv
// axi_wr_pkg: burst, response and region codes plus the FSM state type
// shared by the AXI write interface and its address generator.
package axi_wr_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REGION_FIFO = 2'd0;
    localparam logic [1:0] REGION_IRAM = 2'd1;
    localparam logic [1:0] REGION_WRAM = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic region_valid(input logic [3:0] sel);
        logic ok;
        ok = (sel == 4'b0001) || (sel == 4'b0010) || (sel == 4'b0100);
        return ok;
    endfunction

    function automatic logic [1:0] region_code(input logic [3:0] sel);
        logic [1:0] code;
        case (sel)
            4'b0010: code = REGION_IRAM;
            4'b0100: code = REGION_WRAM;
            default: code = REGION_FIFO;
        endcase
        return code;
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        logic ok;
        ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return ok;
    endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// axi_wr_addr_gen: next beat byte address for FIXED, INCR and WRAP bursts.
module axi_wr_addr_gen
    import axi_wr_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic [ADDR_W-1:0] start,
    input  logic [ADDR_W-1:0] cur,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next
);

    logic [ADDR_W-1:0] beat;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;
    logic [31:0]       span;

    // WRAP containers are a power of two, so wrapping is a masked merge of
    // the container base with the incremented offset.
    always_comb begin
        beat = ADDR_W'(1) << size;
        incr = cur + beat;
        span = (32'(len) + 32'd1) << size;
        mask = ADDR_W'(span - 32'd1);
        case (burst)
            BURST_FIXED: next = start;
            BURST_WRAP:  next = (cur & ~mask) | (incr & mask);
            default:     next = incr;
        endcase
    end

endmodule

// File: rtl/axi_write_intf.sv
// axi_write_intf: AXI4 write slave turning bursts into single-beat internal writes.
// Optional build macro AXI_WR_LEN_CHECK_EN: WLAST/AWLEN disagreement answers SLVERR.
module axi_write_intf
    import axi_wr_pkg::*;
#(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic [3:0]          AWREGION,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVLID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    output logic                axi_wr_vld,
    output logic [ADDR_W-1:0]   axi_wr_addr,
    output logic [DATA_W-1:0]   axi_wr_data,
    output logic [DATA_W/8-1:0] axi_wr_strb,
    output logic [1:0]          axi_wr_region,
    input  logic                fifo_wr_done,
    input  logic                fifo_err,
    input  logic                iram_wr_done,
    input  logic                wram_wr_done
);

    localparam int         STRB_W   = DATA_W / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

    state_t            state;
    state_t            state_nxt;
    logic              live;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        len_q;
    logic [7:0]        cnt_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [1:0]        region_q;
    logic              discard_q;
    logic              slverr_q;
    logic              aw_hs;
    logic              w_hs;
    logic              aw_discard;
    logic              last_beat;
    logic              len_err;
    logic              done_hit;

    // live holds AWREADY low for the first edge after reset release.
    assign AWREADY = live && (state == ST_IDLE);
    assign WREADY  = (state == ST_DATA);
    assign BVALID  = (state == ST_RESP);
    assign BID     = id_q;
    assign BRESP   = slverr_q ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs      = AWVALID && AWREADY;
    assign w_hs       = WVLID && WREADY;
    assign aw_discard = !region_valid(AWREGION) ||
                        ((AWBURST == BURST_WRAP) && !wrap_len_ok(AWLEN));
    assign last_beat  = WLAST || (cnt_q == len_q);

`ifdef AXI_WR_LEN_CHECK_EN
    assign len_err = WLAST != (cnt_q == len_q);
`else
    assign len_err = 1'b0;
`endif

    always_comb begin
        done_hit = 1'b0;
        case (region_q)
            REGION_FIFO: done_hit = fifo_wr_done || fifo_err;
            REGION_IRAM: done_hit = iram_wr_done;
            REGION_WRAM: done_hit = wram_wr_done;
            default:     done_hit = 1'b0;
        endcase
    end

    // Discarded bursts issue no writes, so no completion pulse will come:
    // they go straight to the response.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (aw_hs) state_nxt = ST_DATA;
            ST_DATA: if (w_hs && last_beat) state_nxt = discard_q ? ST_RESP : ST_WAIT;
            ST_WAIT: if (done_hit) state_nxt = ST_RESP;
            ST_RESP: if (BREADY) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q      <= '0;
            start_q   <= '0;
            cur_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            region_q  <= '0;
            discard_q <= 1'b0;
            slverr_q  <= 1'b0;
        end else if (aw_hs) begin
            id_q      <= AWID;
            start_q   <= AWADDR;
            cur_q     <= AWADDR;
            len_q     <= AWLEN;
            cnt_q     <= 8'd0;
            size_q    <= (AWSIZE > MAX_SIZE) ? MAX_SIZE : AWSIZE;
            burst_q   <= AWBURST;
            region_q  <= region_code(AWREGION);
            discard_q <= aw_discard;
            slverr_q  <= aw_discard;
        end else if (w_hs) begin
            cur_q <= next_addr;
            cnt_q <= cnt_q + 8'd1;
            if (last_beat && len_err) slverr_q <= 1'b1;
        end else if ((state == ST_WAIT) && (region_q == REGION_FIFO) && fifo_err) begin
            slverr_q <= 1'b1;
        end
    end

    // Beat stage: the accepted W beat is presented one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axi_wr_vld    <= 1'b0;
            axi_wr_addr   <= '0;
            axi_wr_data   <= '0;
            axi_wr_strb   <= '0;
            axi_wr_region <= '0;
        end else begin
            axi_wr_vld <= w_hs && !discard_q;
            if (w_hs) begin
                axi_wr_addr   <= cur_q;
                axi_wr_data   <= WDATA;
                axi_wr_strb   <= WSTRB;
                axi_wr_region <= region_q;
            end
        end
    end

    axi_wr_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .start(start_q),
        .cur  (cur_q),
        .size (size_q),
        .len  (len_q),
        .burst(burst_q),
        .next (next_addr)
    );

endmodule

// File: tb/tb_axi_write_intf.sv
// tb_axi_write_intf: randomized bursts checked against a burst-level model of
// the address, response and handshake rules of axi_write_intf.
`timescale 1ns/1ps
module tb_axi_write_intf;

    localparam int ID_W = 8, ADDR_W = 11, DATA_W = 32, STRB_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [ID_W-1:0] AWID, BID;
    logic [ADDR_W-1:0] AWADDR, axi_wr_addr;
    logic [7:0] AWLEN;
    logic [2:0] AWSIZE;
    logic [1:0] AWBURST, BRESP, axi_wr_region;
    logic [3:0] AWREGION;
    logic AWVALID, AWREADY, WLAST, WVLID, WREADY, BVALID, BREADY, axi_wr_vld;
    logic [DATA_W-1:0] WDATA, axi_wr_data;
    logic [STRB_W-1:0] WSTRB, axi_wr_strb;
    logic fifo_wr_done, fifo_err, iram_wr_done, wram_wr_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDR_W-1:0] cap_addr[$];
    logic [DATA_W-1:0] cap_data[$];
    logic [STRB_W-1:0] cap_strb[$];
    logic [1:0]        cap_reg[$];
    logic [DATA_W-1:0] drv_data[$];
    logic [STRB_W-1:0] drv_strb[$];

    logic [ID_W-1:0] o_bid;
    logic [1:0] o_bresp;
    bit o_skip, o_stable, o_aw_in_b, o_aw_after, o_bv_after, o_hung;

    always #5 clk = ~clk;

    axi_write_intf dut (
        .clk(clk), .rst_n(rst_n),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWREGION(AWREGION), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVLID(WVLID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .axi_wr_vld(axi_wr_vld), .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data),
        .axi_wr_strb(axi_wr_strb), .axi_wr_region(axi_wr_region),
        .fifo_wr_done(fifo_wr_done), .fifo_err(fifo_err),
        .iram_wr_done(iram_wr_done), .wram_wr_done(wram_wr_done)
    );

    always @(negedge clk) begin
        if (axi_wr_vld === 1'b1) begin
            cap_addr.push_back(axi_wr_addr);
            cap_data.push_back(axi_wr_data);
            cap_strb.push_back(axi_wr_strb);
            cap_reg.push_back(axi_wr_region);
        end
    end

    // ---------------- reference model ----------------
    function automatic int unsigned model_addr(int unsigned start, int unsigned len,
                                               int unsigned size, int unsigned burst, int unsigned i);
        int unsigned sz, span, base;
        sz = 1 << ((size > 2) ? 2 : size);
        if (burst == 0) return start;
        if (burst == 2) begin
            span = (len + 1) * sz;
            base = start - (start % span);
            return base + ((start - base + i * sz) % span);
        end
        return (start + i * sz) % 2048;
    endfunction

    function automatic int model_writes(logic [3:0] rgn, logic [1:0] bt, logic [7:0] len, int wl);
        int nb;
        nb = ((wl < int'(len)) ? wl : int'(len)) + 1;
        if (!(rgn == 4'd1 || rgn == 4'd2 || rgn == 4'd4)) return 0;
        if (bt == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 0;
        return nb;
    endfunction

    function automatic logic [1:0] model_resp(logic [3:0] rgn, logic [1:0] bt, logic [7:0] len,
                                              int wl, bit use_err);
        bit e;
        e = !(rgn == 4'd1 || rgn == 4'd2 || rgn == 4'd4);
        if (bt == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1;
        if (use_err && rgn == 4'd1) e = 1;
`ifdef AXI_WR_LEN_CHECK_EN
        if (wl != int'(len)) e = 1;
`endif
        return e ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] model_region(logic [3:0] rgn);
        return (rgn == 4'd2) ? 2'd1 : (rgn == 4'd4) ? 2'd2 : 2'd0;
    endfunction

    // ---------------- stimulus driver ----------------
    task automatic run_burst(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] region,
                             input int wlast_at, input bit use_err, input bit pre_done,
                             input int stall, input bit seq_data);
        int t, nb;
        cap_addr.delete(); cap_data.delete(); cap_strb.delete(); cap_reg.delete();
        drv_data.delete(); drv_strb.delete();
        o_hung = 0; o_stable = 1; o_aw_in_b = 0;
        nb = ((wlast_at < int'(len)) ? wlast_at : int'(len)) + 1;
        @(negedge clk);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWREGION = region; AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) o_hung = 1;
        @(negedge clk);
        AWVALID = 1'b0;
        if (pre_done) begin
            fifo_wr_done = region[0]; iram_wr_done = region[1]; wram_wr_done = region[2];
            @(negedge clk);
            fifo_wr_done = 1'b0; iram_wr_done = 1'b0; wram_wr_done = 1'b0;
        end
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 2) == 0) begin WVLID = 1'b0; @(negedge clk); end
            WDATA = seq_data ? (32'd404 + 32'(b)) : $urandom;
            WSTRB = seq_data ? 4'hF : 4'($urandom);
            WLAST = (b == wlast_at);
            WVLID = 1'b1;
            drv_data.push_back(WDATA); drv_strb.push_back(WSTRB);
            t = 0;
            while (!WREADY && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) o_hung = 1;
            @(negedge clk);
        end
        WVLID = 1'b0; WLAST = 1'b0;
        t = 0;
        while (!BVALID && t < 3) begin @(negedge clk); t++; end
        o_skip = BVALID;
        if (!BVALID) begin
            if (use_err) fifo_err = 1'b1;
            else begin
                fifo_wr_done = region[0]; iram_wr_done = region[1]; wram_wr_done = region[2];
            end
            @(negedge clk);
            fifo_err = 1'b0; fifo_wr_done = 1'b0; iram_wr_done = 1'b0; wram_wr_done = 1'b0;
        end
        t = 0;
        while (!BVALID && t < 30) begin @(negedge clk); t++; end
        if (t >= 30) o_hung = 1;
        o_bid = BID; o_bresp = BRESP;
        for (int s = 0; s < stall; s++) begin
            if (BVALID !== 1'b1 || BID !== o_bid || BRESP !== o_bresp) o_stable = 0;
            if (AWREADY !== 1'b0) o_aw_in_b = 1;
            @(negedge clk);
        end
        if (AWREADY !== 1'b0) o_aw_in_b = 1;
        BREADY = 1'b1;
        @(negedge clk);
        BREADY = 1'b0;
        o_aw_after = AWREADY; o_bv_after = BVALID;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({AWREADY, WREADY, BVALID, axi_wr_vld} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_handshakes got=%b exp=0000", {AWREADY, WREADY, BVALID, axi_wr_vld}); end
        n_cmp++; if ({BID, BRESP, axi_wr_addr, axi_wr_region} !== '0) begin
            n_bad++; $display("FAIL reset_outputs got bid=%0h bresp=%0h addr=%0h exp=0", BID, BRESP, axi_wr_addr); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (AWREADY !== 1'b1) begin n_bad++; $display("FAIL release_awready got=%b exp=1", AWREADY); end
        n_cmp++; if ({BVALID, axi_wr_vld} !== 2'b00) begin
            n_bad++; $display("FAIL release_idle got=%b exp=00", {BVALID, axi_wr_vld}); end
    endtask

    task automatic test_incr();
        logic [10:0] ea [4];
        ea = '{11'd0, 11'd4, 11'd8, 11'd12};
        run_burst(8'hA5, 11'd0, 8'd3, 3'd2, 2'b01, 4'b0010, 3, 0, 0, 0, 1);
        n_cmp++; if (o_hung !== 1'b0) begin n_bad++; $display("FAIL incr_timeout got=%b exp=0", o_hung); end
        n_cmp++; if (cap_addr.size() !== 4) begin n_bad++; $display("FAIL incr_count got=%0d exp=4", cap_addr.size()); end
        for (int b = 0; b < 4 && b < cap_addr.size(); b++) begin
            n_cmp++; if (cap_addr[b] !== ea[b] || cap_data[b] !== 32'd404 + 32'(b) || cap_reg[b] !== 2'd1) begin
                n_bad++; $display("FAIL incr_beat%0d got addr=%0d data=%0d reg=%0d exp addr=%0d data=%0d reg=1",
                                  b, cap_addr[b], cap_data[b], cap_reg[b], ea[b], 404 + b); end
        end
        n_cmp++; if (o_bid !== 8'hA5 || o_bresp !== 2'b00) begin
            n_bad++; $display("FAIL incr_resp got bid=%0h bresp=%0h exp bid=a5 bresp=0", o_bid, o_bresp); end
        n_cmp++; if (o_skip !== 1'b0) begin n_bad++; $display("FAIL incr_wait_for_done got=%b exp=0", o_skip); end
    endtask

    task automatic test_wrap();
        logic [10:0] ea [4];
        ea = '{11'd8, 11'd12, 11'd0, 11'd4};
        run_burst(8'h3C, 11'd8, 8'd3, 3'd2, 2'b10, 4'b0100, 3, 0, 0, 0, 0);
        n_cmp++; if (cap_addr.size() !== 4) begin n_bad++; $display("FAIL wrap_count got=%0d exp=4", cap_addr.size()); end
        for (int b = 0; b < 4 && b < cap_addr.size(); b++) begin
            n_cmp++; if (cap_addr[b] !== ea[b] || cap_data[b] !== drv_data[b] || cap_reg[b] !== 2'd2) begin
                n_bad++; $display("FAIL wrap_beat%0d got addr=%0d reg=%0d exp addr=%0d reg=2",
                                  b, cap_addr[b], cap_reg[b], ea[b]); end
        end
        n_cmp++; if (o_bresp !== 2'b00) begin n_bad++; $display("FAIL wrap_resp got=%0h exp=0", o_bresp); end
        run_burst(8'h11, 11'd0, 8'd16, 3'd2, 2'b10, 4'b0010, 16, 0, 0, 0, 0);
        n_cmp++; if (cap_addr.size() !== 0) begin n_bad++; $display("FAIL wrap_bad_len_writes got=%0d exp=0", cap_addr.size()); end
        n_cmp++; if (o_bresp !== 2'b10 || o_bid !== 8'h11 || o_hung !== 1'b0) begin
            n_bad++; $display("FAIL wrap_bad_len_resp got bresp=%0h bid=%0h hung=%b exp bresp=2 bid=11 hung=0",
                              o_bresp, o_bid, o_hung); end
    endtask

    task automatic test_region();
        run_burst(8'h21, 11'h40, 8'd1, 3'd2, 2'b01, 4'b0001, 1, 1, 0, 0, 0);
        n_cmp++; if (cap_addr.size() !== 2) begin n_bad++; $display("FAIL fifo_err_count got=%0d exp=2", cap_addr.size()); end
        n_cmp++; if (cap_reg.size() > 0 && cap_reg[0] !== 2'd0) begin
            n_bad++; $display("FAIL fifo_region got=%0d exp=0", cap_reg[0]); end
        n_cmp++; if (o_bresp !== 2'b10) begin n_bad++; $display("FAIL fifo_err_resp got=%0h exp=2", o_bresp); end
        run_burst(8'h22, 11'h80, 8'd2, 3'd2, 2'b01, 4'b1000, 2, 0, 0, 0, 0);
        n_cmp++; if (cap_addr.size() !== 0) begin n_bad++; $display("FAIL decode_err_writes got=%0d exp=0", cap_addr.size()); end
        n_cmp++; if (o_bresp !== 2'b10 || o_skip !== 1'b1 || o_hung !== 1'b0) begin
            n_bad++; $display("FAIL decode_err_resp got bresp=%0h skip=%b hung=%b exp bresp=2 skip=1 hung=0",
                              o_bresp, o_skip, o_hung); end
    endtask

    task automatic test_bready_stall();
        run_burst(8'h5A, 11'h10, 8'd0, 3'd2, 2'b01, 4'b0010, 0, 0, 0, 5, 0);
        n_cmp++; if (o_stable !== 1'b1) begin n_bad++; $display("FAIL stall_b_stable got=%b exp=1", o_stable); end
        n_cmp++; if (o_aw_in_b !== 1'b0) begin n_bad++; $display("FAIL stall_awready_low got=%b exp=0", o_aw_in_b); end
        n_cmp++; if (o_aw_after !== 1'b1 || o_bv_after !== 1'b0) begin
            n_bad++; $display("FAIL after_b_handshake got aw=%b bv=%b exp aw=1 bv=0", o_aw_after, o_bv_after); end
        n_cmp++; if (o_bid !== 8'h5A || o_bresp !== 2'b00) begin
            n_bad++; $display("FAIL stall_resp got bid=%0h bresp=%0h exp bid=5a bresp=0", o_bid, o_bresp); end
    endtask

    task automatic test_done_outside_wait();
        run_burst(8'h66, 11'h20, 8'd1, 3'd2, 2'b01, 4'b0010, 1, 0, 1, 0, 0);
        n_cmp++; if (o_skip !== 1'b0) begin n_bad++; $display("FAIL early_done_ignored got=%b exp=0", o_skip); end
        n_cmp++; if (cap_addr.size() !== 2 || o_bresp !== 2'b00) begin
            n_bad++; $display("FAIL early_done_burst got n=%0d bresp=%0h exp n=2 bresp=0", cap_addr.size(), o_bresp); end
    endtask

    task automatic test_len_check();
        logic [1:0] er;
`ifdef AXI_WR_LEN_CHECK_EN
        er = 2'b10;
`else
        er = 2'b00;
`endif
        run_burst(8'h71, 11'h100, 8'd3, 3'd2, 2'b01, 4'b0010, 1, 0, 0, 0, 0);
        n_cmp++; if (cap_addr.size() !== 2) begin n_bad++; $display("FAIL early_wlast_count got=%0d exp=2", cap_addr.size()); end
        n_cmp++; if (o_bresp !== er) begin n_bad++; $display("FAIL early_wlast_resp got=%0h exp=%0h", o_bresp, er); end
        run_burst(8'h72, 11'h100, 8'd3, 3'd2, 2'b01, 4'b0100, 99, 0, 0, 0, 0);
        n_cmp++; if (cap_addr.size() !== 4) begin n_bad++; $display("FAIL no_wlast_count got=%0d exp=4", cap_addr.size()); end
        n_cmp++; if (o_bresp !== er) begin n_bad++; $display("FAIL no_wlast_resp got=%0h exp=%0h", o_bresp, er); end
    endtask

    task automatic test_reset_mid_burst();
        bit seen_b;
        int t;
        seen_b = 0;
        @(negedge clk);
        AWID = 8'h99; AWADDR = 11'd0; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01;
        AWREGION = 4'b0010; AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        AWVALID = 1'b0; WVLID = 1'b1; WDATA = $urandom; WSTRB = 4'hF; WLAST = 1'b0;
        @(negedge clk);
        WVLID = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({WREADY, BVALID, axi_wr_vld} !== 3'b000) begin
            n_bad++; $display("FAIL midreset_outputs got=%b exp=000", {WREADY, BVALID, axi_wr_vld}); end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (BVALID !== 1'b0) seen_b = 1; end
        n_cmp++; if (seen_b !== 1'b0) begin n_bad++; $display("FAIL midreset_no_resp got=%b exp=0", seen_b); end
        n_cmp++; if (AWREADY !== 1'b1) begin n_bad++; $display("FAIL midreset_awready got=%b exp=1", AWREADY); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] id, len;
        logic [10:0] addr;
        logic [2:0] sz;
        logic [1:0] bt, er;
        logic [3:0] rgn;
        int wl, nw, esz;
        bit ue;
        logic [7:0] wlens [4];
        logic [3:0] rgns [3];
        wlens = '{8'd1, 8'd3, 8'd7, 8'd15};
        rgns = '{4'b0001, 4'b0010, 4'b0100};
        for (int k = 0; k < 8; k++) begin
            id = 8'($urandom);
            bt = 2'($urandom_range(0, 2));
            sz = 3'($urandom_range(0, 3));
            len = (bt == 2'd2) ? wlens[$urandom_range(0, 3)] : 8'($urandom_range(0, 7));
            esz = 1 << ((sz > 3'd2) ? 2 : int'(sz));
            addr = 11'($urandom) & ~11'(esz - 1);
            rgn = rgns[$urandom_range(0, 2)];
            wl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len))) : int'(len);
            ue = (rgn == 4'b0001) && ($urandom_range(0, 2) == 0);
            run_burst(id, addr, len, sz, bt, rgn, wl, ue, 0, $urandom_range(0, 2), 0);
            nw = model_writes(rgn, bt, len, wl);
            er = model_resp(rgn, bt, len, wl, ue);
            n_cmp++; if (cap_addr.size() !== nw || o_hung !== 1'b0) begin
                n_bad++; $display("FAIL b2b%0d_count got=%0d hung=%b exp=%0d hung=0", k, cap_addr.size(), o_hung, nw); end
            for (int i = 0; i < nw && i < cap_addr.size(); i++) begin
                n_cmp++; if (cap_addr[i] !== 11'(model_addr(addr, len, sz, bt, i)) || cap_data[i] !== drv_data[i] ||
                             cap_strb[i] !== drv_strb[i] || cap_reg[i] !== model_region(rgn)) begin
                    n_bad++; $display("FAIL b2b%0d_beat%0d got addr=%0h data=%0h strb=%0h reg=%0d exp addr=%0h data=%0h strb=%0h reg=%0d",
                                      k, i, cap_addr[i], cap_data[i], cap_strb[i], cap_reg[i],
                                      model_addr(addr, len, sz, bt, i), drv_data[i], drv_strb[i], model_region(rgn)); end
            end
            n_cmp++; if (o_bid !== id || o_bresp !== er) begin
                n_bad++; $display("FAIL b2b%0d_resp got bid=%0h bresp=%0h exp bid=%0h bresp=%0h", k, o_bid, o_bresp, id, er); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWREGION = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVLID = 1'b0; BREADY = 1'b0;
        fifo_wr_done = 1'b0; fifo_err = 1'b0; iram_wr_done = 1'b0; wram_wr_done = 1'b0;
        test_reset();
        test_incr();
        test_wrap();
        test_region();
        test_bready_stall();
        test_done_outside_wait();
        test_len_check();
        test_reset_mid_burst();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_write_intf.md
AXI_WRITE_INTF -- requirements
Module: axi_write_intf

Interface
REQ-001 SHALL have parameters: ID_W, default 8, AXI ID width; ADDR_W, default 11, byte address width; DATA_W, default 32, data width.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- AWID  in  ID_W  write ID.
- AWADDR  in  ADDR_W  start byte address.
- AWLEN  in  8  beats-1.
- AWSIZE  in  3  log2 bytes per beat.
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
- AWREGION  in  4  one-hot target select.
- AWVALID in 1; AWREADY out 1.
- WDATA in DATA_W; WSTRB in DATA_W/8; WLAST in 1; WVLID in 1 (W valid); WREADY out 1.
- BID out ID_W; BRESP out 2; BVALID out 1; BREADY in 1.
- axi_wr_vld  out  1  one-cycle internal write strobe.
- axi_wr_addr  out  ADDR_W  beat byte address.
- axi_wr_data  out  DATA_W  beat data.
- axi_wr_strb  out  DATA_W/8  beat byte enables.
- axi_wr_region  out  2  target: 0 FIFO, 1 IRAM, 2 WRAM.
- fifo_wr_done, fifo_err, iram_wr_done, wram_wr_done  in  1  target completion/error pulses.

Function
REQ-003 SHALL implement FSM IDLE -> DATA -> WAIT -> RESP -> IDLE.
REQ-004 IDLE: AWREADY=1; on AWVALID&AWREADY latch AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWREGION; go to DATA.
REQ-005 AWREGION decode: 0001->0 FIFO, 0010->1 IRAM, 0100->2 WRAM; any other value = decode error.
REQ-006 DATA: WREADY=1; each WVLID&WREADY beat drives axi_wr_vld=1 for exactly one cycle the following cycle, with the beat address, WDATA, WSTRB and region registered.
REQ-007 axi_wr_vld SHALL be suppressed on decode error.
REQ-008 Beat size = 2^min(AWSIZE,log2(DATA_W/8)) bytes; AWSIZE above bus width is clamped without error.
REQ-009 FIXED: every beat uses the start address.
REQ-010 INCR: address += beat size per beat, modulo 2^ADDR_W.
REQ-011 WRAP: requires AWLEN in {1,3,7,15}; container = (AWLEN+1)*size aligned down; address wraps to container base at the upper boundary.
REQ-012 Illegal WRAP length: beats accepted and discarded, response SLVERR.
REQ-013 Burst ends on the beat where WLAST=1 or the beat counter reaches AWLEN, whichever is first; then go to WAIT.
REQ-014 WAIT: hold until the done input of the latched region pulses (fifo_wr_done, iram_wr_done or wram_wr_done); a decode error skips WAIT.
REQ-015 fifo_err high in WAIT for region 0 SHALL complete WAIT with SLVERR.
REQ-016 RESP: BVALID=1, BID=latched AWID, BRESP=00 OKAY or 10 SLVERR; hold until BREADY; then IDLE.
REQ-017 BVALID and AWREADY SHALL never both be high; a new AW is accepted the cycle after B handshake at earliest.
REQ-018 Done pulses outside WAIT SHALL be ignored.

Reset
REQ-019 During rst_n low: state IDLE; AWREADY=0, WREADY=0, BVALID=0, axi_wr_vld=0, BID/BRESP/axi_wr_* =0.
REQ-020 AWREADY SHALL assert the first cycle after rst_n deasserts.
REQ-021 Reset mid-burst SHALL abort with no response.

Configuration
REQ-022 With AXI_WR_LEN_CHECK_EN defined, WLAST on a beat other than beat AWLEN, or no WLAST on beat AWLEN, SHALL yield SLVERR; the burst still ends per REQ-013.
REQ-023 Without AXI_WR_LEN_CHECK_EN, WLAST mismatch SHALL be ignored (OKAY).

Structure
REQ-024 Package axi_wr_pkg SHALL hold the burst codes, BRESP codes, region codes and FSM state typedef.
REQ-025 Address generation SHALL be the single sub-module axi_wr_addr_gen (start, size, len, burst -> next address).

Verification
REQ-026 Reset release -> AWREADY=1 next cycle; BVALID=0, axi_wr_vld=0.
REQ-027 INCR: AWADDR=0, AWLEN=3, AWSIZE=2, AWREGION=0010, data 404..407 -> axi_wr_addr 0,4,8,12, region 1; iram_wr_done -> BVALID, BID=AWID, BRESP=00.
REQ-028 WRAP: AWADDR=8, AWLEN=3, AWSIZE=2 -> addresses 8,12,0,4; AWLEN=16 WRAP -> no axi_wr_vld, BRESP=10.
REQ-029 AWREGION=0001 with fifo_err during WAIT -> BRESP=10; AWREGION=1000 -> no axi_wr_vld, BRESP=10 with no WAIT.
REQ-030 BREADY held low 5 cycles -> BVALID, BID, BRESP stable; AWREADY=0 throughout.
REQ-031 AXI_WR_LEN_CHECK_EN, AWLEN=3, WLAST on beat 1 -> burst ends after 2 beats, BRESP=10.
